mc_controller: RTL
==================

// Module: mc_controller
// PURPOSE
//  Multicycle sequencer for the ARM-subset datapath: decodes Instr, steps one instruction across several
//  clocks and drives the datapath controls (RegSrc..Branch) plus fetch/memory strobes. Holds NZCV and
//  evaluates Cond. Shares one memory port between fetch and LDR/STR via a req/ready handshake.
// PARAMETERS
//  CNT_W   32  width of optional performance counters
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  reset         in   1   synchronous, active-low reset
//  Instr         in   32  instruction word (valid from DECODE onward; latched externally under IRWrite)
//  ALUFlags      in   4   {N,Z,C,V} from datapath flag mux
//  mem_ready     in   1   memory completes current access this cycle
//  mem_req       out  1   memory access request (fetch or data)
//  AdrSrc        out  1   0: address=PC (fetch), 1: address=ALUResult (data)
//  IRWrite       out  1   load instruction register
//  PCWrite       out  1   load PC (gated: never asserted for a failed-condition instruction)
//  RegSrc        out  2   datapath RA1/RA2 select
//  RegWrite      out  1   register file write enable
//  ImmSrc        out  2   00 DP imm8, 01 mem imm12, 10 branch imm24
//  ALUSrc        out  1   0: shifted reg, 1: ExtImm
//  ShifterSrc    out  1   1: flags from shifter (MOV), 0: from ALU
//  ALUControl    out  4   0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 pass-B
//  MemtoReg      out  1   write-back from ReadData
//  MemWrite      out  1   data store strobe
//  PCSrc         out  1   PC loads ResultToPc instead of PC+4
//  Branch        out  1   select shifted branch target
//  instr_done    out  1   one-cycle pulse when an instruction retires (incl. condition-failed)
//  illegal_instr out  1   one-cycle pulse in DECODE for unsupported op/cmd
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=FETCH, NZCV=0000. While reset==0 all outputs forced 0.
//  - Moore decode from registered state; Instr fields: Cond[31:28], Op[27:26], I[25], cmd[24:21],
//    S[20], L[20], Rd[15:12]. Op 00 DP, 01 mem, 10 branch, 11 illegal.
//  - FETCH: mem_req=1, AdrSrc=0; hold until mem_ready; on ready IRWrite=1, PCWrite=1 (PC+4) -> DECODE.
//  - DECODE: RegSrc per op; evaluate Cond against registered NZCV (EQ..LE per ARM, 1110 AL, 1111 never).
//    Cond fail or illegal -> FETCH, instr_done=1, no other strobes. Else DP -> EXEC, mem -> MEMADR,
//    branch -> BRANCH.
//  - EXEC: ALUSrc=I; cmd 0100->ADD,0010->SUB,0000->AND,1100->ORR,1010 CMP->SUB,1101 MOV->pass-B with
//    ShifterSrc=1; other cmd = illegal (caught in DECODE). If S==1 latch NZCV<=ALUFlags at end of cycle.
//    CMP -> FETCH with instr_done; else -> ALUWB.
//  - ALUWB: RegWrite=1; if Rd==15 also PCSrc=1, PCWrite=1. instr_done=1 -> FETCH.
//  - MEMADR: ALUSrc=1, ImmSrc=01, ALUControl=ADD -> L ? MEMRD : MEMWR.
//  - MEMRD: mem_req=1, AdrSrc=1; wait mem_ready -> MEMWB. MEMWB: MemtoReg=1, RegWrite=1 (Rd==15 also
//    PCSrc/PCWrite), instr_done=1 -> FETCH.
//  - MEMWR: mem_req=1, MemWrite=1, AdrSrc=1 held until mem_ready; then instr_done=1 -> FETCH.
//  - BRANCH: ImmSrc=10, ALUSrc=1, ALUControl=ADD, Branch=1, PCSrc=1, PCWrite=1, instr_done=1 -> FETCH.
//  - Latency with mem_ready tied 1: B 3, CMP 3, DP 4, STR 4, LDR 5 cycles. Each wait cycle adds 1.
//  - Request must stay asserted with address/strobes stable until mem_ready; mem_ready with mem_req=0
//    is ignored. Reset mid-wait abandons the access (mem_req drops next cycle), no retire pulse.
//  - NZCV never updated in any state other than EXEC, never by a condition-failed instruction.
// CONFIGURATION
//  MC_CTRL_PERF_CNT_EN defined: adds outputs cycle_cnt[CNT_W] (increments every cycle out of reset) and
//    retire_cnt[CNT_W] (increments on instr_done); both wrap modulo 2^CNT_W, cleared by reset.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  - Reset held 3 cycles then released, mem_ready=1 -> first cycle FETCH: mem_req=1, AdrSrc=0, NZCV=0.
//  - ADD R1,R2,#5 (0xE2821005), ready=1 -> states F,D,EXEC,ALUWB; RegWrite only in cycle 4; done cycle 4.
//  - SUBS then BEQ with ALUFlags=0100 in EXEC -> NZCV=0100; BEQ takes BRANCH, PCWrite+Branch asserted.
//  - BNE (0x1A000002) with Z=1 -> DECODE retires, PCWrite=0 in DECODE, back to FETCH in 2 cycles.
//  - LDR with mem_ready low 3 cycles in MEMRD -> mem_req/AdrSrc stable, retire at cycle 8.
//  - STR, reset driven low during MEMWR wait -> next cycle MemWrite=0, state FETCH, no instr_done;
//    with MC_CTRL_PERF_CNT_EN, counters read 0 after reset.

Source files
------------

// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
//   Multicycle sequencer for the ARM-subset datapath. It decodes Instr and
//   steps each instruction through several clocks while driving the datapath
//   selects. It holds the NZCV flags and evaluates the condition field
//   against them. Instruction fetch and LDR/STR share one memory port, which
//   uses a req/ready handshake.
//
//   Optional feature macro: MC_CTRL_PERF_CNT_EN
//     When the macro is defined, the parameter CNT_W (default 32) and the
//     outputs cycle_cnt/retire_cnt exist. Both counters wrap modulo 2^CNT_W
//     and are cleared by reset. When the macro is undefined, the parameter,
//     the ports and the counters are all absent.
//
// Ports
//   clk           in   clock; all state updates on posedge
//   reset         in   synchronous active-low reset; all outputs 0 while low
//   Instr[31:0]   in   instruction word (valid from DECODE onward)
//   ALUFlags[3:0] in   {N,Z,C,V} from datapath flag mux
//   mem_ready     in   memory completes the current access this cycle
//   mem_req       out  memory access request (fetch or data)
//   AdrSrc        out  0: address=PC, 1: address=ALUResult
//   IRWrite       out  load instruction register
//   PCWrite       out  load PC
//   RegSrc[1:0]   out  RA1/RA2 select ([1] STR reads Rd, [0] branch reads PC)
//   RegWrite      out  register file write enable
//   ImmSrc[1:0]   out  00 DP imm8, 01 mem imm12, 10 branch imm24
//   ALUSrc        out  0: shifted reg, 1: ExtImm
//   ShifterSrc    out  1: flags from shifter (MOV)
//   ALUControl    out  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 pass-B
//   MemtoReg      out  write-back from ReadData
//   MemWrite      out  data store strobe
//   PCSrc         out  PC loads ResultToPc
//   Branch        out  select shifted branch target
//   instr_done    out  pulse when an instruction retires
//   illegal_instr out  pulse in DECODE for an unsupported op/cmd
//   cycle_cnt     out  (MC_CTRL_PERF_CNT_EN) cycles spent out of reset
//   retire_cnt    out  (MC_CTRL_PERF_CNT_EN) retired instructions
// ---------------------------------------------------------------------------
module mc_controller
`ifdef MC_CTRL_PERF_CNT_EN
    #(parameter int CNT_W = 32)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrc,
    output logic        ShifterSrc,
    output logic [3:0]  ALUControl,
    output logic        MemtoReg,
    output logic        MemWrite,
    output logic        PCSrc,
    output logic        Branch,
    output logic        instr_done,
    output logic        illegal_instr
`ifdef MC_CTRL_PERF_CNT_EN
   ,output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR,
        S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_ORR  = 4'b0011;
    localparam logic [3:0] ALU_PASS = 4'b0100;

    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    state_t     state_q, state_d;
    logic [3:0] nzcv_q;

    // Instruction fields
    logic [3:0] cond;
    logic [1:0] op;
    logic       i_bit;
    logic [3:0] cmd;
    logic       sl_bit;     // S for data-processing, L for memory
    logic       rd_is_pc;

    assign cond     = Instr[31:28];
    assign op       = Instr[27:26];
    assign i_bit    = Instr[25];
    assign cmd      = Instr[24:21];
    assign sl_bit   = Instr[20];
    assign rd_is_pc = (Instr[15:12] == 4'hF);

    // Register numbers and immediates are consumed by the datapath only.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

    // Condition check against the registered flags.
    logic cond_pass;
    logic flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z, flag_c, flag_v} = nzcv_q;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Data-processing command decode. An unsupported cmd is flagged here.
    // It never reaches EXEC.
    logic       dp_legal;
    logic [3:0] dp_alu;

    always_comb begin
        dp_legal = 1'b1;
        dp_alu   = ALU_ADD;
        case (cmd)
            4'b0100: dp_alu = ALU_ADD;
            4'b0010: dp_alu = ALU_SUB;
            4'b0000: dp_alu = ALU_AND;
            4'b1100: dp_alu = ALU_ORR;
            CMD_CMP: dp_alu = ALU_SUB;
            CMD_MOV: dp_alu = ALU_PASS;
            default: dp_legal = 1'b0;
        endcase
    end

    logic illegal_op;
    assign illegal_op = (op == 2'b11) || ((op == 2'b00) && !dp_legal);

    // NOTE: this block gives every output a value before the case statement.
    // Without that, a path that skips an assignment would infer a latch.
    always_comb begin
        state_d       = S_FETCH;
        mem_req       = 1'b0;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        RegSrc        = 2'b00;
        RegWrite      = 1'b0;
        ImmSrc        = 2'b00;
        ALUSrc        = 1'b0;
        ShifterSrc    = 1'b0;
        ALUControl    = ALU_ADD;
        MemtoReg      = 1'b0;
        MemWrite      = 1'b0;
        PCSrc         = 1'b0;
        Branch        = 1'b0;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;

        // While reset is low the defaults hold, so every strobe stays 0.
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    state_d = S_FETCH;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    RegSrc        = {(op == 2'b01) && !sl_bit, op == 2'b10};
                    illegal_instr = illegal_op;
                    if (illegal_op || !cond_pass) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        case (op)
                            2'b00:   state_d = S_EXEC;
                            2'b01:   state_d = S_MEMADR;
                            default: state_d = S_BRANCH;
                        endcase
                    end
                end
                S_EXEC: begin
                    ALUSrc     = i_bit;
                    ALUControl = dp_alu;
                    ShifterSrc = (cmd == CMD_MOV);
                    if (cmd == CMD_CMP) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_ALUWB;
                    end
                end
                S_ALUWB: begin
                    RegWrite   = 1'b1;
                    PCSrc      = rd_is_pc;
                    PCWrite    = rd_is_pc;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMADR: begin
                    ALUSrc     = 1'b1;
                    ImmSrc     = 2'b01;
                    ALUControl = ALU_ADD;
                    state_d    = sl_bit ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                    state_d = mem_ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    MemtoReg   = 1'b1;
                    RegWrite   = 1'b1;
                    PCSrc      = rd_is_pc;
                    PCWrite    = rd_is_pc;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req    = 1'b1;
                    AdrSrc     = 1'b1;
                    MemWrite   = 1'b1;
                    instr_done = mem_ready;
                    state_d    = mem_ready ? S_FETCH : S_MEMWR;
                end
                S_BRANCH: begin
                    ImmSrc     = 2'b10;
                    ALUSrc     = 1'b1;
                    ALUControl = ALU_ADD;
                    Branch     = 1'b1;
                    PCSrc      = 1'b1;
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // NOTE: reset is sampled on the clock edge. A reset that arrives during a
    // memory wait abandons the access, and the next cycle starts a new fetch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            nzcv_q  <= 4'b0000;
        end else begin
            // NOTE: state registers use non-blocking assignments. Every
            // process then sees the values from before the edge.
            state_q <= state_d;
            // Only a data-processing instruction whose condition passed
            // reaches EXEC. No other path can write the flags.
            if (state_q == S_EXEC && sl_bit) begin
                nzcv_q <= ALUFlags;
            end
        end
    end

`ifdef MC_CTRL_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
            if (instr_done) begin
                retire_cnt <= retire_cnt + CNT_ONE;
            end
        end
    end
`endif

endmodule
